// File: rtl/tc_accum_if.sv
// Stream bundle for tc_accum: input beat handshake plus result handshake.
// The DUT side uses the slave modport, the producer/consumer side the master modport.
interface tc_accum_if #(
  parameter int unsigned TILE_M  = 4,
  parameter int unsigned DW_DATA = 8,
  parameter int unsigned DW_ACC  = 32,
  parameter int unsigned CNT_W   = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [TILE_M*DW_DATA-1:0] in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [TILE_M*DW_ACC-1:0]  out_data;
  logic [CNT_W-1:0]          out_count;
  logic [TILE_M-1:0]         out_sat;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_sat
  );
endinterface

// File: rtl/tc_accum.sv
// Per-lane wide accumulator behind tc_array; closes a group on in_last or MAX_BEATS.
// Optional macro TC_ACC_SAT_EN: saturating per-beat adds with sticky per-lane out_sat.
module tc_accum #(
  parameter int unsigned TILE_M    = 4,
  parameter int unsigned DW_DATA   = 8,
  parameter int unsigned DW_ACC    = 32,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic       clk,
  input  logic       reset,
  tc_accum_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_e;

  state_e state_q, state_d;

  logic [TILE_M-1:0][DW_ACC-1:0] acc_q, acc_d;
  logic [TILE_M-1:0][DW_ACC-1:0] out_data_q, out_data_d;
  logic [TILE_M-1:0][DW_ACC-1:0] sum;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [CNT_W-1:0]              out_count_q, out_count_d;
  logic [CNT_W-1:0]              cnt_inc;
  logic [DW_DATA-1:0]            lane;
  logic [DW_ACC-1:0]             ext;

  logic out_valid;
  logic in_ready;
  logic accept;
  logic consume;
  logic close;

`ifdef TC_ACC_SAT_EN
  localparam logic [DW_ACC-1:0] ACC_MAX = {1'b0, {(DW_ACC-1){1'b1}}};
  localparam logic [DW_ACC-1:0] ACC_MIN = {1'b1, {(DW_ACC-1){1'b0}}};

  logic [DW_ACC:0]   wide;
  logic [TILE_M-1:0] lane_clamp;
  logic [TILE_M-1:0] sat_q, sat_d;
  logic [TILE_M-1:0] out_sat_q, out_sat_d;
`endif

  assign out_valid = (state_q == S_HOLD);
  assign in_ready  = !out_valid || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  assign consume   = out_valid && bus.out_ready;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign close     = accept && (bus.in_last || (cnt_inc == CNT_W'(MAX_BEATS)));

  // Per-lane add of the sign-extended beat onto the running sum.
  always_comb begin
    sum  = '0;
    lane = '0;
    ext  = '0;
`ifdef TC_ACC_SAT_EN
    wide       = '0;
    lane_clamp = '0;
`endif
    for (int unsigned i = 0; i < TILE_M; i++) begin
      lane = bus.in_data[i*DW_DATA +: DW_DATA];
      ext  = {{(DW_ACC-DW_DATA){lane[DW_DATA-1]}}, lane};
`ifdef TC_ACC_SAT_EN
      // One guard bit: overflow iff the two top bits of the widened sum disagree.
      wide = {acc_q[i][DW_ACC-1], acc_q[i]} + {ext[DW_ACC-1], ext};
      if (wide[DW_ACC] != wide[DW_ACC-1]) begin
        sum[i]        = wide[DW_ACC] ? ACC_MIN : ACC_MAX;
        lane_clamp[i] = 1'b1;
      end else begin
        sum[i] = wide[DW_ACC-1:0];
      end
`else
      sum[i] = acc_q[i] + ext;
`endif
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
`ifdef TC_ACC_SAT_EN
    sat_d       = sat_q;
    out_sat_d   = out_sat_q;
`endif
    if (accept) begin
      if (close) begin
        out_data_d  = sum;
        out_count_d = cnt_inc;
        acc_d       = '0;
        cnt_d       = '0;
`ifdef TC_ACC_SAT_EN
        out_sat_d   = sat_q | lane_clamp;
        sat_d       = '0;
`endif
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
`ifdef TC_ACC_SAT_EN
        sat_d = sat_q | lane_clamp;
`endif
      end
    end
  end

  // HOLD is left only by a consume; a same-cycle close reloads and stays in HOLD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ACC: begin
        if (close) begin
          state_d = S_HOLD;
        end else if (accept) begin
          state_d = S_ACC;
        end
      end
      S_HOLD: begin
        if (close) begin
          state_d = S_HOLD;
        end else if (consume) begin
          state_d = accept ? S_ACC : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

`ifdef TC_ACC_SAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q     <= '0;
      out_sat_q <= '0;
    end else begin
      sat_q     <= sat_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign bus.out_sat = out_sat_q;
`else
  assign bus.out_sat = '0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_tc_accum.sv
// Scoreboard bench for tc_accum: three instances (default, MAX_BEATS=4, DW_ACC=10).
// Stimulus pushes hand-computed results; per-instance monitors pop on each consume.
`timescale 1ns/1ps
module tb_tc_accum;

  typedef struct packed {
    int l0;
    int l1;
    int l2;
    int l3;
    int count;
    int sat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tc_accum_if #(.TILE_M(4), .DW_DATA(8), .DW_ACC(32), .CNT_W(5)) bus0 ();
  tc_accum_if #(.TILE_M(4), .DW_DATA(8), .DW_ACC(32), .CNT_W(5)) bus1 ();
  tc_accum_if #(.TILE_M(4), .DW_DATA(8), .DW_ACC(10), .CNT_W(5)) bus2 ();

  tc_accum #(.TILE_M(4), .DW_DATA(8), .DW_ACC(32), .MAX_BEATS(16), .CNT_W(5))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  tc_accum #(.TILE_M(4), .DW_DATA(8), .DW_ACC(32), .MAX_BEATS(4), .CNT_W(5))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  tc_accum #(.TILE_M(4), .DW_DATA(8), .DW_ACC(10), .MAX_BEATS(16), .CNT_W(5))
    u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_res(input string tag, input exp_t e, input int a0, input int a1,
                         input int a2, input int a3, input int cnt, input int sat);
    check({tag, "_lane0"}, a0, e.l0);
    check({tag, "_lane1"}, a1, e.l1);
    check({tag, "_lane2"}, a2, e.l2);
    check({tag, "_lane3"}, a3, e.l3);
    check({tag, "_count"}, cnt, e.count);
    check({tag, "_sat"}, sat, e.sat);
  endtask

  task automatic push(input int d, input int l0, input int l1, input int l2, input int l3,
                      input int cnt, input int sat);
    exp_t e;
    e.l0 = l0; e.l1 = l1; e.l2 = l2; e.l3 = l3; e.count = cnt; e.sat = sat;
    case (d)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int d, input logic v, input logic [31:0] data, input logic last);
    case (d)
      0: begin bus0.in_valid = v; bus0.in_data = data; bus0.in_last = last; end
      1: begin bus1.in_valid = v; bus1.in_data = data; bus1.in_last = last; end
      default: begin bus2.in_valid = v; bus2.in_data = data; bus2.in_last = last; end
    endcase
  endtask

  task automatic set_ready(input int d, input logic r);
    case (d)
      0:       bus0.out_ready = r;
      1:       bus1.out_ready = r;
      default: bus2.out_ready = r;
    endcase
  endtask

  task automatic beat(input int d, input logic [31:0] data, input logic last);
    drv(d, 1'b1, data, last);
    clk_step();
  endtask

  task automatic idle(input int d);
    drv(d, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitors: a consume happens at the next rising edge when valid&&ready at the falling edge.
  always @(negedge clk) begin
    if (!reset && bus0.out_valid && bus0.out_ready) begin
      if (sb0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected: result count %0d with nothing expected", bus0.out_count);
      end else begin
        cmp_res("dut0", sb0.pop_front(),
                int'(bus0.out_data[31:0]), int'(bus0.out_data[63:32]),
                int'(bus0.out_data[95:64]), int'(bus0.out_data[127:96]),
                int'(bus0.out_count), int'(bus0.out_sat));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus1.out_valid && bus1.out_ready) begin
      if (sb1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected: result count %0d with nothing expected", bus1.out_count);
      end else begin
        cmp_res("dut1", sb1.pop_front(),
                int'(bus1.out_data[31:0]), int'(bus1.out_data[63:32]),
                int'(bus1.out_data[95:64]), int'(bus1.out_data[127:96]),
                int'(bus1.out_count), int'(bus1.out_sat));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus2.out_valid && bus2.out_ready) begin
      if (sb2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2_unexpected: result count %0d with nothing expected", bus2.out_count);
      end else begin
        cmp_res("dut2", sb2.pop_front(),
                int'($signed(bus2.out_data[9:0])), int'($signed(bus2.out_data[19:10])),
                int'($signed(bus2.out_data[29:20])), int'($signed(bus2.out_data[39:30])),
                int'(bus2.out_count), int'(bus2.out_sat));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      idle(d);
      set_ready(d, 1'b1);
    end
    #12;
    check("rst_valid0",  int'(bus0.out_valid), 0);
    check("rst_data0",   int'(|bus0.out_data), 0);
    check("rst_count0",  int'(bus0.out_count), 0);
    check("rst_sat0",    int'(bus0.out_sat), 0);
    check("rst_ready0",  int'(bus0.in_ready), 1);
    check("rst_valid1",  int'(bus1.out_valid), 0);
    check("rst_valid2",  int'(bus2.out_valid), 0);
    check("rst_data2",   int'(|bus2.out_data), 0);
    #1 reset = 1'b0;
    clk_step();

    // Three beats of {1,2,3,4}, last on the third.
    push(0, 3, 6, 9, 12, 3, 0);
    beat(0, 32'h04030201, 1'b0);
    beat(0, 32'h04030201, 1'b0);
    check("t1_valid_early", int'(bus0.out_valid), 0);
    beat(0, 32'h04030201, 1'b1);
    check("t1_valid", int'(bus0.out_valid), 1);
    idle(0);
    clk_step();
    check("t1_valid_drop", int'(bus0.out_valid), 0);

    // Negative lanes.
    push(0, -2, -256, 10, 0, 2, 0);
    beat(0, 32'h000580FF, 1'b0);
    beat(0, 32'h000580FF, 1'b1);
    idle(0);
    clk_step();

    // Backpressure, then consume and close in the same cycle.
    set_ready(0, 1'b0);
    push(0, 10, 12, 14, 16, 2, 0);
    beat(0, 32'h08070605, 1'b0);
    beat(0, 32'h08070605, 1'b1);
    drv(0, 1'b1, 32'h09090909, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t3_in_ready", int'(bus0.in_ready), 0);
      check("t3_hold_valid", int'(bus0.out_valid), 1);
      check("t3_hold_lane0", int'(bus0.out_data[31:0]), 10);
      check("t3_hold_lane3", int'(bus0.out_data[127:96]), 16);
      check("t3_hold_count", int'(bus0.out_count), 2);
      clk_step();
    end
    set_ready(0, 1'b1);
    push(0, 7, 7, 7, 7, 1, 0);
    beat(0, 32'h07070707, 1'b1);
    check("t3_b2b_valid", int'(bus0.out_valid), 1);
    check("t3_b2b_count", int'(bus0.out_count), 1);
    idle(0);
    clk_step();
    check("t3_drained", int'(bus0.out_valid), 0);

    // Forced close at MAX_BEATS=4, remainder closed by in_last.
    push(1, 4, 4, 4, 4, 4, 0);
    push(1, 3, 3, 3, 3, 3, 0);
    for (int i = 0; i < 6; i++) beat(1, 32'h01010101, 1'b0);
    beat(1, 32'h01010101, 1'b1);
    idle(1);
    clk_step();

    // DW_ACC=10: five beats of 127 on lane 0.
`ifdef TC_ACC_SAT_EN
    push(2, 511, 0, 0, 0, 5, 1);
`else
    push(2, -389, 0, 0, 0, 5, 0);
`endif
    for (int i = 0; i < 4; i++) beat(2, 32'h0000007F, 1'b0);
    beat(2, 32'h0000007F, 1'b1);
    idle(2);
    clk_step();

    // Reset mid-group with a held result: cleared without a clock edge.
    beat(0, 32'h09090909, 1'b0);
    beat(0, 32'h09090909, 1'b0);
    set_ready(0, 1'b0);
    beat(0, 32'h01010101, 1'b1);
    idle(0);
    check("t6_held", int'(bus0.out_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", int'(bus0.out_valid), 0);
    check("t6_rst_data",  int'(|bus0.out_data), 0);
    check("t6_rst_count", int'(bus0.out_count), 0);
    check("t6_rst_ready", int'(bus0.in_ready), 1);
    #1 reset = 1'b0;
    clk_step();
    set_ready(0, 1'b1);
    push(0, 1, 2, 3, 4, 1, 0);
    beat(0, 32'h04030201, 1'b1);
    idle(0);
    clk_step();
    clk_step();

    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);
    check("sb2_drained", sb2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
